// File: rtl/sub_2p_pkg.sv
// sub_2p shared definitions: default slice split
// and the stage-1 payload layout.
package sub_2p_pkg;

    localparam int WIDTH_D = 16;
    localparam int LSB_D   = 8;
    localparam int MSB_D   = 8;

    // Stage-1 payload at the default split.
    typedef struct packed {
        logic [LSB_D-1:0] d_lo;
        logic             b_lo;
        logic [MSB_D-1:0] x_hi;
        logic [MSB_D-1:0] y_hi;
    } s1_t;

endpackage

// File: rtl/sub_2p_if.sv
// sub_2p handshake bundle: input operands and
// output result, each with its own valid/ready pair.
interface sub_2p_if
    import sub_2p_pkg::*;
#(
    parameter int WIDTH = WIDTH_D
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid,
        output x,
        output y,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow
    );

endinterface

// File: rtl/sub_2p_slice.sv
// sub_slice: combinational N-bit a - b - bin
// with borrow-out taken from the extra top bit.
module sub_slice #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] res;

    assign res  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    assign diff = res[N-1:0];
    assign bout = res[N];

endmodule

// File: rtl/sub_2p.sv
// sub_2p: two-stage split-borrow unsigned subtractor
// with valid/ready on both ends.
module sub_2p
    import sub_2p_pkg::*;
#(
    parameter int WIDTH     = WIDTH_D,
    parameter int LSB_WIDTH = LSB_D,
    parameter int MSB_WIDTH = MSB_D
) (
    input logic     clk,
    input logic     rst_n,
    sub_2p_if.slave io
);

    if (LSB_WIDTH + MSB_WIDTH != WIDTH) begin : g_bad_split
        $fatal(1, "sub_2p: LSB_WIDTH + MSB_WIDTH must equal WIDTH");
    end

    typedef struct packed {
        logic [LSB_WIDTH-1:0] d_lo;
        logic                 b_lo;
        logic [MSB_WIDTH-1:0] x_hi;
        logic [MSB_WIDTH-1:0] y_hi;
    } s1_p_t;

    s1_p_t                s1_q;
    logic                 s1_valid;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     diff_q;
    logic                 borrow_q;
    logic                 s1_en;
    logic                 s2_en;
    logic [LSB_WIDTH-1:0] lo_d;
    logic                 lo_b;
    logic [MSB_WIDTH-1:0] hi_d;
    logic                 hi_b;

    // A stage may load when it is empty or its successor moves.
    assign s2_en = !out_valid_q || io.out_ready;
    assign s1_en = !s1_valid || s2_en;

    assign io.in_ready  = s1_en;
    assign io.out_valid = out_valid_q;
    assign io.diff      = diff_q;
    assign io.borrow    = borrow_q;

    sub_slice #(
        .N (LSB_WIDTH)
    ) u_lo (
        .a    (io.x[LSB_WIDTH-1:0]),
        .b    (io.y[LSB_WIDTH-1:0]),
        .bin  (1'b0),
        .diff (lo_d),
        .bout (lo_b)
    );

    sub_slice #(
        .N (MSB_WIDTH)
    ) u_hi (
        .a    (s1_q.x_hi),
        .b    (s1_q.y_hi),
        .bin  (s1_q.b_lo),
        .diff (hi_d),
        .bout (hi_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
                s1_q.d_lo <= lo_d;
                s1_q.b_lo <= lo_b;
                s1_q.x_hi <= io.x[WIDTH-1:LSB_WIDTH];
                s1_q.y_hi <= io.y[WIDTH-1:LSB_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                diff_q   <= {hi_d, s1_q.d_lo};
                borrow_q <= hi_b;
            end
        end
    end

endmodule

// File: tb/tb_sub_2p.sv
// tb_sub_2p: vector table, backpressure, streaming and
// reset sequences over three slice configurations.
module tb_sub_2p;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [15:0] d16;
        logic        b16;
        logic [31:0] d32;
        logic        b32;
    } vec_t;

    typedef struct {
        logic [15:0] d16;
        logic        b16;
        logic [31:0] d32;
        logic        b32;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x32;
    logic [31:0] y32;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vt[6];

    logic        prev_stall = 1'b0;
    logic [16:0] prev_d = '0;

    sub_2p_if #(.WIDTH(16)) bi ();
    sub_2p_if #(.WIDTH(16)) ni ();
    sub_2p_if #(.WIDTH(32)) wi ();

    assign bi.in_valid  = in_valid;
    assign bi.out_ready = out_ready;
    assign bi.x         = x32[15:0];
    assign bi.y         = y32[15:0];
    assign ni.in_valid  = in_valid;
    assign ni.out_ready = out_ready;
    assign ni.x         = x32[15:0];
    assign ni.y         = y32[15:0];
    assign wi.in_valid  = in_valid;
    assign wi.out_ready = out_ready;
    assign wi.x         = x32;
    assign wi.y         = y32;

    sub_2p #(.WIDTH(16), .LSB_WIDTH(8), .MSB_WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bi)
    );

    sub_2p #(.WIDTH(16), .LSB_WIDTH(4), .MSB_WIDTH(12)) u_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ni)
    );

    sub_2p #(.WIDTH(32), .LSB_WIDTH(16), .MSB_WIDTH(16)) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (wi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bi.out_valid, 1);
                chk("stall_data", {bi.diff, bi.borrow}, prev_d);
            end
            if (bi.out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_diff16", bi.diff, e.d16);
                    chk("sb_borrow16", bi.borrow, e.b16);
                    chk("sb_vld_narrow", ni.out_valid, 1);
                    chk("sb_diff_narrow", ni.diff, e.d16);
                    chk("sb_borrow_narrow", ni.borrow, e.b16);
                    chk("sb_vld_wide", wi.out_valid, 1);
                    chk("sb_diff32", wi.diff, e.d32);
                    chk("sb_borrow32", wi.borrow, e.b32);
                end
            end
            if (in_valid && bi.in_ready) begin
                exp_t e;
                e.d16 = x32[15:0] - y32[15:0];
                e.b16 = x32[15:0] < y32[15:0];
                e.d32 = x32 - y32;
                e.b32 = x32 < y32;
                sb.push_back(e);
            end
            prev_stall = bi.out_valid && !out_ready;
            prev_d     = {bi.diff, bi.borrow};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        x32       = vt[i].x;
        y32       = vt[i].y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_accept", i), bi.in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_lat1", i), bi.out_valid, 0);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_lat2", i), bi.out_valid, 1);
        chk($sformatf("v%0d_diff", i), bi.diff, vt[i].d16);
        chk($sformatf("v%0d_borrow", i), bi.borrow, vt[i].b16);
        chk($sformatf("v%0d_n_diff", i), ni.diff, vt[i].d16);
        chk($sformatf("v%0d_n_borrow", i), ni.borrow, vt[i].b16);
        chk($sformatf("v%0d_w_diff", i), wi.diff, vt[i].d32);
        chk($sformatf("v%0d_w_borrow", i), wi.borrow, vt[i].b32);
        repeat (3) step();
    endtask

    task automatic drive_vec(input int i);
        x32 = vt[i].x;
        y32 = vt[i].y;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_n;
        int  cyc;
        logic acc;

        vt[0] = '{32'h0000_1234, 32'h0000_0034, 16'h1200, 1'b0,
                  32'h0000_1200, 1'b0};
        vt[1] = '{32'h0000_0100, 32'h0000_0001, 16'h00FF, 1'b0,
                  32'h0000_00FF, 1'b0};
        vt[2] = '{32'h0000_0000, 32'h0000_0001, 16'hFFFF, 1'b1,
                  32'hFFFF_FFFF, 1'b1};
        vt[3] = '{32'h8000_8000, 32'h8000_8000, 16'h0000, 1'b0,
                  32'h0000_0000, 1'b0};
        vt[4] = '{32'h0001_0010, 32'h0000_0001, 16'h000F, 1'b0,
                  32'h0001_000F, 1'b0};
        vt[5] = '{32'h0001_0000, 32'h0000_0001, 16'hFFFF, 1'b1,
                  32'h0000_FFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x32       = '0;
        y32       = '0;
        #3;
        chk("rst_out_valid", bi.out_valid, 0);
        chk("rst_diff", bi.diff, 0);
        chk("rst_borrow", bi.borrow, 0);
        chk("rst_in_ready", bi.in_ready, 1);
        chk("rst_w_valid", wi.out_valid, 0);
        chk("rst_w_diff", wi.diff, 0);
        #9;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", bi.in_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure: two accepted, third waits for out_ready.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_vec(0);
        @(negedge clk);
        chk("bp_acc0", bi.in_ready, 1);
        step();
        drive_vec(2);
        @(negedge clk);
        chk("bp_acc1", bi.in_ready, 1);
        step();
        drive_vec(1);
        repeat (2) begin
            @(negedge clk);
            chk("bp_full", bi.in_ready, 0);
            chk("bp_hold", bi.diff, vt[0].d16);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", bi.in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_drain", sb.size(), 0);

        // Random streaming with random consumer stalls.
        acc_n    = 0;
        cyc      = 0;
        in_valid = 1'b1;
        x32      = $urandom;
        y32      = $urandom;
        while (acc_n < 1000 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bi.in_ready;
            step();
            cyc++;
            if (acc) begin
                acc_n++;
                x32 = $urandom;
                y32 = (acc_n % 16 == 0) ? x32 : $urandom;
            end
        end
        chk("stream_count", acc_n, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("stream_drain", sb.size(), 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_vec(3);
        step();
        drive_vec(4);
        step();
        in_valid = 1'b0;
        chk("mid_full_valid", bi.out_valid, 1);
        chk("mid_full_rdy", bi.in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bi.out_valid, 0);
        chk("mid_rst_diff", bi.diff, 0);
        chk("mid_rst_in_ready", bi.in_ready, 1);
        chk("mid_rst_w_valid", wi.out_valid, 0);
        sb.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        run_vec(5);
        chk("mid_rst_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_2p.md
# sub_2p

Two-stage pipelined unsigned subtractor, the counterpart of the team's split-carry pipelined adder. It computes diff = x − y modulo 2^WIDTH and reports a borrow flag. The datapath is split into an LSB slice and an MSB slice, with the LSB borrow registered between stages. Both ends use a valid/ready handshake, so the block can sit between a producer and a consumer that may stall, at full throughput of one result per cycle.

## Interface
- WIDTH, 16, total operand and result width
- LSB_WIDTH, 8, width of the stage-1 (low) slice
- MSB_WIDTH, 8, width of the stage-2 (high) slice; LSB_WIDTH + MSB_WIDTH must equal WIDTH (elaboration-time check, fatal otherwise)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  x/y are valid this cycle
- in_ready  output  1  block accepts x/y this cycle
- x  input  WIDTH  minuend, unsigned
- y  input  WIDTH  subtrahend, unsigned
- out_valid  output  1  diff/borrow are valid
- out_ready  input  1  consumer accepts diff/borrow this cycle
- diff  output  WIDTH  (x − y) mod 2^WIDTH
- borrow  output  1  1 iff x < y (unsigned)

## Operation
- An input transfer occurs on a rising edge with in_valid && in_ready. An output transfer occurs on a rising edge with out_valid && out_ready.
- Stage 1 on accept:
  - registers d_lo = x[LSB-1:0] − y[LSB-1:0] and b_lo = (x_lo < y_lo);
  - registers x_hi and y_hi;
  - sets s1_valid.
- Stage 2 on advance:
  - registers diff = {x_hi − y_hi − b_lo, d_lo};
  - borrow = borrow-out of the MSB slice including b_lo;
  - sets out_valid.
- All arithmetic is unsigned. Each slice is computed at slice width + 1 and the top bit is taken as borrow-out. No sign extension.
- Stall control:
  - s2_en = !out_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en (combinational; no dependence on in_valid)
- Valid bits:
  - On s2_en, out_valid <= s1_valid.
  - On s1_en, s1_valid <= in_valid.
  - Data registers load only on their stage enable. When a stage is not enabled, its data holds unchanged (stable under stall).
- Ordering is strictly FIFO. The block holds at most 2 transactions. No transaction is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, s1_valid = 0, diff = 0, borrow = 0, and all stage-1 registers = 0;
  - in_ready = 1 while in reset and immediately after.
- Latency: an input accepted at edge N produces out_valid = 1 after edge N+1, given no stall. It is transferred at edge N+2 if out_ready = 1.
- Throughput: one transfer per cycle with out_ready held high. in_ready stays 1 continuously.
- Full condition: out_valid && s1_valid && !out_ready. In that state in_ready = 0, and x/y are ignored even if in_valid = 1.
- Simultaneous events:
  - With both stages full and out_ready = 1 on the same cycle, the output transfers, stage 1 advances, and a new input is accepted; in_ready = 1 that cycle.
  - An empty stage 1 with a stalled stage 2 still accepts one input.
- Wrap-around: x < y yields the 2^WIDTH-complement result with borrow = 1, e.g. 0x0000 − 0x0001 = 0xFFFF, borrow 1.
- Reset asserted mid-operation discards both in-flight transactions at once. out_valid falls asynchronously. The first post-reset result appears 2 edges after the first accept.

## Structure
- Package sub_2p_pkg holds:
  - default WIDTH, LSB_WIDTH and MSB_WIDTH constants;
  - a typedef for the stage-1 payload struct (d_lo, b_lo, x_hi, y_hi).
- Sub-module sub_slice #(N): purely combinational N-bit a − b − bin, giving diff[N-1:0] and bout.
  - Instantiated once per stage: LSB with bin = 0, MSB with bin = b_lo.
- Top level contains the two pipeline register banks and the stall logic.

## Test plan
- Basic cases, each followed by 2 idle cycles (out_ready = 1):
  - x = 0x1234, y = 0x0034 -> diff = 0x1200, borrow = 0, exactly 2 edges after accept.
  - Cross-slice borrow: x = 0x0100, y = 0x0001 -> diff = 0x00FF, borrow = 0.
  - Wrap: x = 0x0000, y = 0x0001 -> diff = 0xFFFF, borrow = 1.
  - x = 0x8000, y = 0x8000 -> diff = 0x0000, borrow = 0.
- Backpressure:
  - Hold out_ready = 0 and offer 3 back-to-back inputs: 2 are accepted, then in_ready = 0 with diff/borrow stable.
  - Raise out_ready: all 3 results emerge in order with no loss.
- Streaming: 1000 random x/y with in_valid = 1 and random out_ready (50%) -> a scoreboard matches every output to x − y and x < y in order, and every stall cycle has stable outputs.
- Reset mid-stream:
  - Assert rst_n = 0 with both stages full -> out_valid = 0 immediately, diff = 0, in_ready = 1.
  - After release, the first result is the first post-reset input.
- Parameter sweep: repeat the basic cases with WIDTH = 16 / LSB_WIDTH = 4 / MSB_WIDTH = 12 and with WIDTH = 32 / 16 / 16 -> identical pass criteria.
